// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state type for the instruction-fetch stage
package fetch_pkg;

    localparam int unsigned FETCH_N = 32;
    localparam int unsigned FETCH_R = 6;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - control, instruction-memory and IF/ID signals of the fetch stage
interface fetch_stage_if
    import fetch_pkg::*;
#(
    parameter int N = FETCH_N,
    parameter int R = FETCH_R
);

    logic         stall;
    logic         flush;
    logic         redirect;
    logic [N-1:0] redirect_pc;
    logic [R-1:0] imem_addr;
    logic [N-1:0] imem_data;
    logic [N-1:0] ifid_instr;
    logic [N-1:0] ifid_pc;
    logic         ifid_valid;
    logic         halted;

    modport slave (
        input  stall, flush, redirect, redirect_pc, imem_data,
        output imem_addr, ifid_instr, ifid_pc, ifid_valid, halted
    );

    modport master (
        output stall, flush, redirect, redirect_pc, imem_data,
        input  imem_addr, ifid_instr, ifid_pc, ifid_valid, halted
    );

endinterface

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with synchronous reset, redirect load, hold and increment
module pc_reg
    import fetch_pkg::*;
#(
    parameter int N = FETCH_N
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [N-1:0] i_load_pc,
    input  logic         i_hold,
    output logic [N-1:0] o_pc
);

    logic [N-1:0] r_pc;

    // Load beats hold so a redirect always wins over a stall; the low two bits are forced to keep pc word-aligned.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= {i_load_pc[N-1:2], 2'b00};
        end else if (!i_hold) begin
            r_pc <= r_pc + N'(PC_STEP);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch FSM and IF/ID register; FETCH_HALT_EN enables stop at the last ROM word
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int N = FETCH_N,
    parameter int R = FETCH_R
) (
    input  logic          i_clk,
    input  logic          i_reset,
    fetch_stage_if.slave  bus
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [N-1:0] w_pc;
    logic         w_pc_load;
    logic         w_pc_hold;
    logic         w_ifid_bubble;
    logic         w_ifid_capture;
    logic         w_last_word;

    logic [N-1:0] r_ifid_instr;
    logic [N-1:0] r_ifid_pc;
    logic         r_ifid_valid;

    pc_reg #(.N(N)) u_pc_reg (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (w_pc_load),
        .i_load_pc (bus.redirect_pc),
        .i_hold    (w_pc_hold),
        .o_pc      (w_pc)
    );

    assign bus.imem_addr = w_pc[R+1:2];
    assign w_last_word   = (w_pc[R+1:2] == {R{1'b1}});

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: BOOT leaves on the first unstalled (or redirected) edge; HALT is terminal until reset.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT:    if (!bus.stall || bus.redirect) w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = r_state;
        endcase
`ifdef FETCH_HALT_EN
        if (w_ifid_capture && w_last_word) w_state_next = HALT;
`endif
    end

    // Datapath controls: redirect > flush > stall > normal fetch; HALT only inserts bubbles.
    always_comb begin
        w_pc_load      = 1'b0;
        w_pc_hold      = 1'b1;
        w_ifid_bubble  = 1'b0;
        w_ifid_capture = 1'b0;
        if (r_state == HALT) begin
            w_ifid_bubble = 1'b1;
        end else if (bus.redirect) begin
            w_pc_load     = 1'b1;
            w_ifid_bubble = 1'b1;
        end else if (bus.flush) begin
            w_ifid_bubble = 1'b1;
            w_pc_hold     = bus.stall;
        end else if (!bus.stall) begin
            w_ifid_capture = 1'b1;
`ifdef FETCH_HALT_EN
            w_pc_hold      = w_last_word;
`else
            w_pc_hold      = 1'b0;
`endif
        end
    end

    // IF/ID pipeline register: bubble, capture of the ROM word at pc, or hold.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ifid_instr <= N'(NOP);
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
        end else if (w_ifid_bubble) begin
            r_ifid_instr <= N'(NOP);
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
        end else if (w_ifid_capture) begin
            r_ifid_instr <= bus.imem_data;
            r_ifid_pc    <= w_pc;
            r_ifid_valid <= 1'b1;
        end
    end

    assign bus.ifid_instr = r_ifid_instr;
    assign bus.ifid_pc    = r_ifid_pc;
    assign bus.ifid_valid = r_ifid_valid;

`ifdef FETCH_HALT_EN
    logic r_halted;

    // halted trails entry into HALT by one edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= (r_state == HALT);
        end
    end

    assign bus.halted = r_halted;
`else
    assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage (honours FETCH_HALT_EN)
module tb_fetch_stage;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    assign bus.imem_data = 32'hA000_0000 + {26'd0, bus.imem_addr};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic [5:0]  addr;
        logic        halted;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_pc;
    int          m_state;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_valid;
    logic        m_halted;

    // Advance the reference model by one edge, push its prediction, clock the DUT, then pop and compare.
    task automatic cycle();
        exp_t        e;
        logic [31:0] npc;
        int          nst;
        npc = m_pc;
        nst = m_state;
        if (reset) begin
            npc = 0; nst = M_BOOT;
            m_instr = 0; m_ipc = 0; m_valid = 0; m_halted = 0;
        end else begin
            m_halted = (m_state == M_HALT);
            if (m_state == M_HALT) begin
                m_instr = 0; m_ipc = 0; m_valid = 0;
            end else if (bus.redirect) begin
                npc = {bus.redirect_pc[31:2], 2'b00};
                m_instr = 0; m_ipc = 0; m_valid = 0;
                nst = M_RUN;
            end else if (bus.flush) begin
                if (!bus.stall) npc = m_pc + 4;
                m_instr = 0; m_ipc = 0; m_valid = 0;
                nst = (m_state == M_BOOT && bus.stall) ? M_BOOT : M_RUN;
            end else if (!bus.stall) begin
                m_instr = 32'hA000_0000 + {26'd0, m_pc[7:2]};
                m_ipc   = m_pc;
                m_valid = 1;
                npc     = m_pc + 4;
                nst     = M_RUN;
`ifdef FETCH_HALT_EN
                if (m_pc[7:2] == 6'h3F) begin
                    npc = m_pc;
                    nst = M_HALT;
                end
`endif
            end
        end
        m_pc    = npc;
        m_state = nst;
        e.instr  = m_instr;
        e.pc     = m_ipc;
        e.valid  = m_valid;
        e.addr   = m_pc[7:2];
        e.halted = m_halted;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("sb_instr",  bus.ifid_instr, e.instr);
        check_eq("sb_pc",     bus.ifid_pc, e.pc);
        check_eq("sb_valid",  {31'd0, bus.ifid_valid}, {31'd0, e.valid});
        check_eq("sb_addr",   {26'd0, bus.imem_addr}, {26'd0, e.addr});
        check_eq("sb_halted", {31'd0, bus.halted}, {31'd0, e.halted});
    endtask

    task automatic drive(input logic rst, input logic s, input logic f, input logic rd, input logic [31:0] rpc);
        reset           = rst;
        bus.stall       = s;
        bus.flush       = f;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
    endtask

    initial begin
        m_pc = 0; m_state = M_BOOT; m_instr = 0; m_ipc = 0; m_valid = 0; m_halted = 0;
        drive(1, 0, 0, 0, 0);
        cycle();
        cycle();
        check_eq("rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
        check_eq("rst_addr",  {26'd0, bus.imem_addr}, 32'd0);

        drive(0, 0, 0, 0, 0);
        check_eq("boot_addr", {26'd0, bus.imem_addr}, 32'd0);
        cycle();
        check_eq("word0_instr", bus.ifid_instr, 32'hA000_0000);
        check_eq("word0_pc",    bus.ifid_pc, 32'd0);
        check_eq("word0_valid", {31'd0, bus.ifid_valid}, 32'd1);
        cycle();
        check_eq("word1_instr", bus.ifid_instr, 32'hA000_0001);
        check_eq("word1_pc",    bus.ifid_pc, 32'd4);

        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("stall_addr",  {26'd0, bus.imem_addr}, 32'd2);
            check_eq("stall_instr", bus.ifid_instr, 32'hA000_0001);
        end
        drive(0, 0, 0, 0, 0);
        cycle();
        check_eq("unstall_instr", bus.ifid_instr, 32'hA000_0002);
        check_eq("unstall_pc",    bus.ifid_pc, 32'd8);

        drive(0, 0, 0, 1, 32'h0000_003E);
        cycle();
        check_eq("redir_valid", {31'd0, bus.ifid_valid}, 32'd0);
        check_eq("redir_addr",  {26'd0, bus.imem_addr}, 32'd15);
        drive(0, 0, 0, 0, 0);
        cycle();
        check_eq("redir_instr", bus.ifid_instr, 32'hA000_000F);
        check_eq("redir_pc",    bus.ifid_pc, 32'h3C);

        drive(0, 0, 0, 1, 32'h10);
        cycle();
        drive(0, 1, 1, 0, 0);
        cycle();
        check_eq("fs_valid", {31'd0, bus.ifid_valid}, 32'd0);
        check_eq("fs_addr",  {26'd0, bus.imem_addr}, 32'd4);
        drive(0, 0, 0, 0, 0);
        cycle();
        check_eq("fs_instr", bus.ifid_instr, 32'hA000_0004);
        check_eq("fs_pc",    bus.ifid_pc, 32'd16);

        check_eq("pre_rst_valid", {31'd0, bus.ifid_valid}, 32'd1);
        drive(1, 0, 0, 0, 0);
        cycle();
        check_eq("mid_rst_instr", bus.ifid_instr, 32'd0);
        check_eq("mid_rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
        check_eq("mid_rst_addr",  {26'd0, bus.imem_addr}, 32'd0);
        drive(0, 1, 0, 0, 0);
        cycle();
        check_eq("boot_stall_valid", {31'd0, bus.ifid_valid}, 32'd0);
        drive(0, 0, 0, 0, 0);
        cycle();
        check_eq("reboot_instr", bus.ifid_instr, 32'hA000_0000);

        for (int i = 0; i < 20; i++) begin
            drive(0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, 32'($urandom_range(0, 127)));
            cycle();
        end

        drive(0, 0, 0, 1, 32'h0FC);
        cycle();
        check_eq("last_addr", {26'd0, bus.imem_addr}, 32'd63);
        drive(0, 0, 0, 0, 0);
        cycle();
        check_eq("last_instr", bus.ifid_instr, 32'hA000_003F);
        check_eq("last_pc",    bus.ifid_pc, 32'h0FC);
`ifdef FETCH_HALT_EN
        cycle();
        check_eq("halt_flag",  {31'd0, bus.halted}, 32'd1);
        check_eq("halt_valid", {31'd0, bus.ifid_valid}, 32'd0);
        drive(0, 1, 0, 1, 32'h0);
        cycle();
        check_eq("halt_redir_valid", {31'd0, bus.ifid_valid}, 32'd0);
        check_eq("halt_redir_addr",  {26'd0, bus.imem_addr}, 32'd63);
        check_eq("halt_hold_flag",   {31'd0, bus.halted}, 32'd1);
`else
        cycle();
        check_eq("wrap_instr", bus.ifid_instr, 32'hA000_0000);
        check_eq("wrap_pc",    bus.ifid_pc, 32'h100);
        check_eq("wrap_halt",  {31'd0, bus.halted}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
